// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute stage plus EX/WB pipeline register of the 4-stage
// 8-bit pipeline (IF, ID, EX, WB).
//
// Inputs:
//   Clk, Reset            : clock, synchronous active-high reset
//   Data1_ID_EX           : Rs1 register-file value (operand A source)
//   Data2_ID_EX           : Rd register-file value (two-address operand B)
//   extended_ID_EX        : sign-extended immediate / jump target
//   Rd_ID_EX, Rs1_ID_EX   : destination / source register indices
//   RegWrite_ID_EX, ALUctrl_ID_EX (0 ADD, 1 MOV), ALUsrc_ID_EX (1 = imm),
//   jump_ID_EX            : decoded controls
// Outputs:
//   Result_EX_WB, Rd_EX_WB, RegWrite_EX_WB : registered write-back bundle
//   pc_load, pc_target, flush_IF_ID        : combinational jump redirect
//   zero_flag, carry_flag                  : registered ALU flags
//   retired_count                          : count of non-squashed instructions
module ex_wb_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Data1_ID_EX,
  input  logic [7:0]  Data2_ID_EX,
  input  logic [7:0]  extended_ID_EX,
  input  logic [2:0]  Rd_ID_EX,
  input  logic [2:0]  Rs1_ID_EX,
  input  logic        RegWrite_ID_EX,
  input  logic        ALUctrl_ID_EX,
  input  logic        ALUsrc_ID_EX,
  input  logic        jump_ID_EX,
  output logic [7:0]  Result_EX_WB,
  output logic [2:0]  Rd_EX_WB,
  output logic        RegWrite_EX_WB,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic        flush_IF_ID,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic [15:0] retired_count
);

  // Number of wrong-path instructions still to be squashed after a jump.
  logic [1:0] squash_cnt;
  logic       valid;
  logic       take_jump;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [8:0] sum;
  logic [7:0] alu_r;
  logic       alu_c;

  always_comb begin
    valid     = (squash_cnt == 2'd0);
    take_jump = valid && jump_ID_EX;

    // Distance-1 forwarding from the instruction currently in WB; squashed
    // and jump instructions never have RegWrite_EX_WB set, so never forward.
    op_a = (RegWrite_EX_WB && (Rd_EX_WB == Rs1_ID_EX)) ? Result_EX_WB : Data1_ID_EX;
    if (ALUsrc_ID_EX)
      op_b = extended_ID_EX;
    else if (RegWrite_EX_WB && (Rd_EX_WB == Rd_ID_EX))
      op_b = Result_EX_WB;
    else
      op_b = Data2_ID_EX;

    sum = {1'b0, op_a} + {1'b0, op_b};
    if (ALUctrl_ID_EX) begin
      alu_r = op_b;
      alu_c = 1'b0;
    end else begin
      alu_r = sum[7:0];
      alu_c = sum[8];
    end

    pc_load     = take_jump && !Reset;
    pc_target   = extended_ID_EX;
    flush_IF_ID = pc_load;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Result_EX_WB   <= '0;
      Rd_EX_WB       <= '0;
      RegWrite_EX_WB <= 1'b0;
      zero_flag      <= 1'b0;
      carry_flag     <= 1'b0;
      retired_count  <= '0;
      squash_cnt     <= '0;
    end else begin
      // Squashed instructions still move through EX/WB, just without a write.
      Result_EX_WB   <= alu_r;
      Rd_EX_WB       <= Rd_ID_EX;
      RegWrite_EX_WB <= valid && !jump_ID_EX && RegWrite_ID_EX;

      if (valid && !jump_ID_EX) begin
        zero_flag  <= (alu_r == 8'd0);
        carry_flag <= alu_c;
      end

      if (valid)
        retired_count <= retired_count + 16'd1;

      if (take_jump)
        squash_cnt <= 2'd2;
      else if (squash_cnt != 2'd0)
        squash_cnt <= squash_cnt - 2'd1;
    end
  end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Execute stage and EX/WB pipeline register of the 4-stage 8-bit pipelined processor (IF, ID, EX, WB). The block consumes the ID/EX register outputs and computes the ALU result, forwarding operands from the instruction in WB. It registers the result, destination and write enable into EX/WB for the register file. It also resolves jumps, squashing the two wrong-path instructions behind a taken jump, and keeps Z/C flags and a retired-instruction counter.

## Interface
- No parameters; data width 8, register index width 3.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset, sampled on rising edge of Clk.
- Data1_ID_EX  in  8  register-file value of Rs1.
- Data2_ID_EX  in  8  register-file value of Rd (two-address ADD source).
- extended_ID_EX  in  8  sign-extended immediate / jump target.
- Rd_ID_EX, Rs1_ID_EX  in  3  destination and source indices.
- RegWrite_ID_EX, ALUctrl_ID_EX, ALUsrc_ID_EX, jump_ID_EX  in  1  decoded controls.
- Result_EX_WB  out  8  registered write-back data.
- Rd_EX_WB  out  3  registered destination.
- RegWrite_EX_WB  out  1  registered write enable.
- pc_load  out  1  combinational; jump taken this cycle.
- pc_target  out  8  combinational; equals extended_ID_EX.
- flush_IF_ID  out  1  combinational; equals pc_load.
- zero_flag, carry_flag  out  1  registered ALU flags.
- retired_count  out  16  registered count of non-squashed instructions.

## Operation
- Valid instruction in EX: squash_cnt == 0. A squashed instruction still advances EX/WB but with RegWrite_EX_WB forced 0. It does not update flags or retired_count, and its jump is ignored.
- Operand A: if RegWrite_EX_WB and Rd_EX_WB == Rs1_ID_EX, use Result_EX_WB; otherwise use Data1_ID_EX.
- Operand B: if ALUsrc_ID_EX = 1, use extended_ID_EX.
  - Otherwise, if RegWrite_EX_WB and Rd_EX_WB == Rd_ID_EX, use Result_EX_WB.
  - Otherwise use Data2_ID_EX.
- ALUctrl_ID_EX = 0: ADD, {c, r} = A + B as a 9-bit sum.
- ALUctrl_ID_EX = 1: MOV, r = B, c = 0.
- Flags on a valid, non-jump instruction: zero_flag <= (r == 0) and carry_flag <= c. Flags hold otherwise.
- Jump, when valid and jump_ID_EX = 1:
  - pc_load = 1 and pc_target = extended_ID_EX.
  - RegWrite_EX_WB <= 0 regardless of RegWrite_ID_EX.
  - squash_cnt <= 2.
- squash_cnt is a 2-bit counter: loaded to 2 by a jump, otherwise decremented by 1 each cycle while nonzero.
- retired_count increments by 1 per valid instruction, jumps included. It wraps from 0xFFFF to 0x0000.

## Timing
- Result latency: 1 cycle from the ID/EX values to Result_EX_WB.
- Forwarding covers a back-to-back dependency, distance 1. The register file writes in WB, so distance 2 or more reads the updated register.
- After a jump in cycle N:
  - Cycles N+1 and N+2 are squashed.
  - The target instruction reaches EX in cycle N+3.
  - A jump during cycles N+1 or N+2 does not assert pc_load.
- Reset, synchronous, any cycle including mid-squash:
  - Result_EX_WB = 0, Rd_EX_WB = 0, RegWrite_EX_WB = 0.
  - zero_flag = 0, carry_flag = 0, retired_count = 0, squash_cnt = 0.
  - pc_load is forced 0 in a cycle where Reset = 1.
- Rd_EX_WB == Rs1_ID_EX == Rd_ID_EX: both operands forward.
- Forwarding uses only RegWrite_EX_WB. A squashed or jump instruction has RegWrite_EX_WB = 0, so it never forwards.

## Test plan
- Reset, then MOV R1, #0x05 (ALUsrc = 1, ALUctrl = 1) -> next cycle Result_EX_WB = 0x05, Rd_EX_WB = 1, RegWrite_EX_WB = 1, zero_flag = 0, retired_count = 1.
- MOV R2, #0xFF, then ADD R2, R1 with stale Data2 = 0x00 and Data1 = 0x05 -> B forwarded as 0xFF; result 0x04, carry_flag = 1, zero_flag = 0.
- MOV R3, #0x80, then ADD R3, R3 (Rs1 = Rd = 3) -> both operands forwarded; result 0x00, zero_flag = 1, carry_flag = 1.
- Jump with extended = 0x2A -> same cycle pc_load = 1, pc_target = 0x2A, flush_IF_ID = 1. The next two instructions (including a jump and a MOV with RegWrite = 1) produce RegWrite_EX_WB = 0, no pc_load, and no retired_count change. The third instruction executes normally.
- Assert Reset during the first squash cycle -> all outputs zero next edge. The following instruction executes without squash.
- Preload retired_count to 0xFFFF via 65535 valid instructions, then one more -> retired_count = 0x0000.
